// File: rtl/cpm_arb_mt.sv
// ----------------------------------------------------------------------------
// cpm_arb_mt
// Multi-target round-robin arbiter. Each target (bank) independently picks one
// of the requesters currently pointing at it, searching upward from its own
// round-robin pointer. Grants are combinational: zero-cycle latency.
//
// Optional feature (macro CPM_ARB_MT_LOCK_EN):
//   defined   - multi-beat bursts lock a target to its owner until the beat
//               carrying req_last; the pointer advances only on that beat.
//   undefined - req_last is ignored, tgt_lock is always 0, and the pointer
//               advances on every granted beat.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   req_vld   - per-requester request valid
//   req_tgt   - per-requester target index, requester i at [i*TGT_AW +: TGT_AW]
//   req_last  - per-requester final-beat marker
//   gnt       - per-requester grant (beat moves when req_vld & gnt)
//   tgt_vld   - target t is receiving a beat this cycle
//   tgt_src   - requester served by target t, [t*REQ_AW +: REQ_AW], 0 if idle
//   tgt_lock  - registered, target t is locked to a burst owner
// ----------------------------------------------------------------------------
module cpm_arb_mt #(
    parameter int REQ_NUM = 4,
    parameter int TGT_NUM = 4,
    parameter int REQ_AW  = $clog2(REQ_NUM),
    parameter int TGT_AW  = $clog2(TGT_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req_vld,
    input  logic [REQ_NUM*TGT_AW-1:0] req_tgt,
    input  logic [REQ_NUM-1:0]        req_last,
    output logic [REQ_NUM-1:0]        gnt,
    output logic [TGT_NUM-1:0]        tgt_vld,
    output logic [TGT_NUM*REQ_AW-1:0] tgt_src,
    output logic [TGT_NUM-1:0]        tgt_lock
);

    logic [REQ_AW-1:0] ptr_q [TGT_NUM];
    logic [REQ_AW-1:0] ptr_d [TGT_NUM];
    logic [REQ_AW-1:0] win   [TGT_NUM];
    logic [TGT_AW-1:0] tgt_of [REQ_NUM];

    // Wrap-around increment used to move the pointer past the last winner.
    function automatic logic [REQ_AW-1:0] next_ptr(input logic [REQ_AW-1:0] w);
        return (w == REQ_AW'(REQ_NUM - 1)) ? '0 : w + 1'b1;
    endfunction

    // Unpack the flat target-index bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            tgt_of[i] = req_tgt[i*TGT_AW +: TGT_AW];
        end
    end

`ifdef CPM_ARB_MT_LOCK_EN
    typedef enum logic {IDLE, LOCK} lock_state_t;

    lock_state_t       state_q [TGT_NUM];
    lock_state_t       state_d [TGT_NUM];
    logic [REQ_AW-1:0] own_q   [TGT_NUM];
    logic [REQ_AW-1:0] own_d   [TGT_NUM];
    logic [REQ_NUM-1:0] owned;

    // Requesters that currently own a lock somewhere; every other target
    // must ignore them so a burst owner is never served twice.
    always_comb begin
        owned = '0;
        for (int t = 0; t < TGT_NUM; t++) begin
            if (state_q[t] == LOCK) begin
                owned[own_q[t]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < TGT_NUM; t++) begin
            tgt_lock[t] = (state_q[t] == LOCK);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign tgt_lock    = '0;
`endif

    // Per-target arbitration. A locked target only considers its owner; an
    // unlocked one scans from its pointer upward with wrap. Each requester
    // names a single target, so it can win at most one target per cycle.
    always_comb begin
        int                r;
        logic              hit;
        logic              elig;
        logic [REQ_AW-1:0] ridx;
        gnt     = '0;
        tgt_vld = '0;
        tgt_src = '0;
        r       = 0;
        hit     = 1'b0;
        elig    = 1'b0;
        ridx    = '0;
        for (int t = 0; t < TGT_NUM; t++) begin
            win[t] = '0;
        end
        if (!rst) begin
            for (int t = 0; t < TGT_NUM; t++) begin
                hit = 1'b0;
                for (int k = 0; k < REQ_NUM; k++) begin
                    r = int'(ptr_q[t]) + k;
                    if (r >= REQ_NUM) begin
                        r = r - REQ_NUM;
                    end
                    ridx = REQ_AW'(r);
                    elig = req_vld[ridx] && (tgt_of[ridx] == TGT_AW'(t));
`ifdef CPM_ARB_MT_LOCK_EN
                    if (state_q[t] == LOCK) begin
                        elig = elig && (own_q[t] == ridx);
                    end else begin
                        elig = elig && !owned[ridx];
                    end
`endif
                    if (!hit && elig) begin
                        hit    = 1'b1;
                        win[t] = ridx;
                    end
                end
                if (hit) begin
                    tgt_vld[t]                  = 1'b1;
                    tgt_src[t*REQ_AW +: REQ_AW] = win[t];
                    gnt[win[t]]                 = 1'b1;
                end
            end
        end
    end

    // Next-state: pointer movement and, when locking is built in, the
    // IDLE/LOCK transitions driven by each completed beat.
    always_comb begin
        for (int t = 0; t < TGT_NUM; t++) begin
            ptr_d[t] = ptr_q[t];
`ifdef CPM_ARB_MT_LOCK_EN
            state_d[t] = state_q[t];
            own_d[t]   = own_q[t];
`endif
        end
        for (int t = 0; t < TGT_NUM; t++) begin
            if (tgt_vld[t]) begin
`ifdef CPM_ARB_MT_LOCK_EN
                if (req_last[win[t]]) begin
                    ptr_d[t]   = next_ptr(win[t]);
                    state_d[t] = IDLE;
                end else if (state_q[t] == IDLE) begin
                    state_d[t] = LOCK;
                    own_d[t]   = win[t];
                end
`else
                ptr_d[t] = next_ptr(win[t]);
`endif
            end
        end
    end

    // State registers; reset drops any lock and gives requester 0 priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TGT_NUM; t++) begin
                ptr_q[t] <= '0;
`ifdef CPM_ARB_MT_LOCK_EN
                state_q[t] <= IDLE;
                own_q[t]   <= '0;
`endif
            end
        end else begin
            ptr_q <= ptr_d;
`ifdef CPM_ARB_MT_LOCK_EN
            state_q <= state_d;
            own_q   <= own_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpm_arb_mt.sv
// ----------------------------------------------------------------------------
// tb_cpm_arb_mt
// Self-checking bench for cpm_arb_mt with 4 requesters and 4 targets.
// Directed scenarios compare against hand-derived constants; a randomized
// scenario compares against a behavioural model of the arbitration rules.
// Expectations follow the CPM_ARB_MT_LOCK_EN build setting.
// ----------------------------------------------------------------------------
module tb_cpm_arb_mt;

`ifdef CPM_ARB_MT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_vld;
    logic [7:0] req_tgt;
    logic [3:0] req_last;
    logic [3:0] gnt;
    logic [3:0] tgt_vld;
    logic [7:0] tgt_src;
    logic [3:0] tgt_lock;

    int checks = 0;
    int errors = 0;

    // Behavioural model state for the randomized scenario.
    int m_ptr  [4];
    int m_own  [4];
    bit m_lock [4];

    cpm_arb_mt dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_tgt  (req_tgt),
        .req_last (req_last),
        .gnt      (gnt),
        .tgt_vld  (tgt_vld),
        .tgt_src  (tgt_src),
        .tgt_lock (tgt_lock)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are compared
    // 2 units later, well away from either clock edge.
    task automatic do_reset();
        rst      = 1'b1;
        req_vld  = '0;
        req_tgt  = '0;
        req_last = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req_vld  = 4'hF;
        req_tgt  = 8'($urandom);
        req_last = 4'($urandom);
        #2;
        checks++;
        if (gnt !== 4'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b exp %b", gnt, 4'b0); end
        checks++;
        if (tgt_vld !== 4'b0) begin errors++; $display("[TB] FAIL reset_tgt_vld got %b exp %b", tgt_vld, 4'b0); end
        checks++;
        if (tgt_src !== 8'b0) begin errors++; $display("[TB] FAIL reset_tgt_src got %h exp %h", tgt_src, 8'b0); end
        @(posedge clk);
        #1;
        checks++;
        if (tgt_lock !== 4'b0) begin errors++; $display("[TB] FAIL reset_lock got %b exp %b", tgt_lock, 4'b0); end
        rst      = 1'b0;
        req_tgt  = 8'h00;
        req_last = 4'hF;
        #2;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL reset_prio got %b exp %b", gnt, 4'b0001); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        do_reset();
        req_vld  = 4'hF;
        req_tgt  = 8'h00;
        req_last = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #2;
            e = 4'b0001 << c;
            checks++;
            if (gnt !== e) begin errors++; $display("[TB] FAIL rr_gnt cycle %0d got %b exp %b", c, gnt, e); end
            checks++;
            if (tgt_src[1:0] !== 2'(c)) begin errors++; $display("[TB] FAIL rr_src cycle %0d got %0d exp %0d", c, tgt_src[1:0], c); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_parallel();
        do_reset();
        req_vld  = 4'hF;
        req_tgt  = 8'b11_10_01_00;
        req_last = 4'hF;
        #2;
        checks++;
        if (gnt !== 4'b1111) begin errors++; $display("[TB] FAIL par_gnt got %b exp %b", gnt, 4'b1111); end
        checks++;
        if (tgt_vld !== 4'b1111) begin errors++; $display("[TB] FAIL par_vld got %b exp %b", tgt_vld, 4'b1111); end
        checks++;
        if (tgt_src !== 8'b11_10_01_00) begin errors++; $display("[TB] FAIL par_src got %b exp %b", tgt_src, 8'b11100100); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst();
        logic [3:0] exp_lk [4];
        logic [3:0] exp_rr [4];
        logic [3:0] e;
        logic [1:0] es;
        logic       el;
        int         beats;
        exp_lk = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
        exp_rr = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        do_reset();
        req_vld = 4'b1010;
        req_tgt = 8'b10_00_10_00;
        beats   = 0;
        for (int c = 0; c < 4; c++) begin
            req_last = {1'b1, 1'b0, (beats == 2), 1'b0};
            #2;
            e  = LOCK_EN ? exp_lk[c] : exp_rr[c];
            es = (e == 4'b0010) ? 2'd1 : 2'd3;
            el = LOCK_EN && (c == 1 || c == 2);
            checks++;
            if (gnt !== e) begin errors++; $display("[TB] FAIL burst_gnt cycle %0d got %b exp %b", c, gnt, e); end
            checks++;
            if (tgt_src[5:4] !== es) begin errors++; $display("[TB] FAIL burst_src cycle %0d got %0d exp %0d", c, tgt_src[5:4], es); end
            checks++;
            if (tgt_lock[2] !== el) begin errors++; $display("[TB] FAIL burst_lock cycle %0d got %b exp %b", c, tgt_lock[2], el); end
            if (gnt[1]) beats++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_lk [5];
        logic [3:0] exp_rr [5];
        logic [3:0] vld    [5];
        logic [3:0] e;
        logic       el;
        exp_lk = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
        exp_rr = '{4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b1000};
        vld    = '{4'b1010, 4'b1000, 4'b1000, 4'b1010, 4'b1010};
        do_reset();
        req_tgt = 8'b10_00_10_00;
        for (int c = 0; c < 5; c++) begin
            req_vld  = vld[c];
            req_last = {1'b1, 1'b0, (c == 3), 1'b0};
            #2;
            e  = LOCK_EN ? exp_lk[c] : exp_rr[c];
            el = LOCK_EN && (c >= 1 && c <= 3);
            checks++;
            if (gnt !== e) begin errors++; $display("[TB] FAIL stall_gnt cycle %0d got %b exp %b", c, gnt, e); end
            checks++;
            if (tgt_lock[2] !== el) begin errors++; $display("[TB] FAIL stall_lock cycle %0d got %b exp %b", c, tgt_lock[2], el); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req_tgt  = 8'h00;
        req_vld  = 4'b0100;
        req_last = 4'b0000;
        #2;
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL mid_start got %b exp %b", gnt, 4'b0100); end
        @(posedge clk);
        #1;
        checks++;
        if (tgt_lock[0] !== LOCK_EN) begin errors++; $display("[TB] FAIL mid_locked got %b exp %b", tgt_lock[0], LOCK_EN); end
        rst     = 1'b1;
        req_vld = 4'hF;
        #2;
        checks++;
        if (gnt !== 4'b0) begin errors++; $display("[TB] FAIL mid_rst_gnt got %b exp %b", gnt, 4'b0); end
        @(posedge clk);
        #1;
        checks++;
        if (tgt_lock !== 4'b0) begin errors++; $display("[TB] FAIL mid_unlock got %b exp %b", tgt_lock, 4'b0); end
        rst      = 1'b0;
        req_last = 4'hF;
        #2;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL mid_prio got %b exp %b", gnt, 4'b0001); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int         w [4];
        int         r;
        int         o;
        bit         busy;
        logic [3:0] eg;
        logic [3:0] ev;
        logic [7:0] es;
        logic [3:0] el;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            m_ptr[t]  = 0;
            m_own[t]  = 0;
            m_lock[t] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            req_vld = 4'($urandom);
            req_tgt = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_last[i] = ($urandom_range(0, 2) == 0);
            end
            eg = '0;
            ev = '0;
            es = '0;
            el = '0;
            for (int t = 0; t < 4; t++) begin
                w[t] = -1;
                el[t] = LOCK_EN && m_lock[t];
                if (rst) continue;
                if (LOCK_EN && m_lock[t]) begin
                    o = m_own[t];
                    if (req_vld[o[1:0]] && req_tgt[{o[1:0], 1'b0} +: 2] == t[1:0]) w[t] = o;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        r = (m_ptr[t] + k) % 4;
                        busy = 1'b0;
                        for (int u = 0; u < 4; u++) begin
                            if (LOCK_EN && m_lock[u] && m_own[u] == r) busy = 1'b1;
                        end
                        if (w[t] < 0 && req_vld[r[1:0]] && req_tgt[{r[1:0], 1'b0} +: 2] == t[1:0] && !busy) w[t] = r;
                    end
                end
                if (w[t] >= 0) begin
                    eg[w[t][1:0]]         = 1'b1;
                    ev[t[1:0]]            = 1'b1;
                    es[{t[1:0], 1'b0} +: 2] = w[t][1:0];
                end
            end
            #2;
            checks++;
            if (gnt !== eg) begin errors++; $display("[TB] FAIL rand_gnt step %0d got %b exp %b", n, gnt, eg); end
            checks++;
            if (tgt_vld !== ev) begin errors++; $display("[TB] FAIL rand_vld step %0d got %b exp %b", n, tgt_vld, ev); end
            checks++;
            if (tgt_src !== es) begin errors++; $display("[TB] FAIL rand_src step %0d got %b exp %b", n, tgt_src, es); end
            checks++;
            if (tgt_lock !== el) begin errors++; $display("[TB] FAIL rand_lock step %0d got %b exp %b", n, tgt_lock, el); end
            @(posedge clk);
            for (int t = 0; t < 4; t++) begin
                if (rst) begin
                    m_ptr[t]  = 0;
                    m_own[t]  = 0;
                    m_lock[t] = 1'b0;
                end else if (w[t] >= 0) begin
                    if (!LOCK_EN || req_last[w[t][1:0]]) begin
                        m_ptr[t]  = (w[t] + 1) % 4;
                        m_lock[t] = 1'b0;
                    end else if (!m_lock[t]) begin
                        m_lock[t] = 1'b1;
                        m_own[t]  = w[t];
                    end
                end
            end
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req_vld  = '0;
        req_tgt  = '0;
        req_last = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_parallel();
        test_burst();
        test_stall();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
